// File: rtl/ca_rule_inferrer.sv
// Elementary-CA rule inferrer: scans each (previous, current) generation pair one cell
// per clock and records every neighbourhood -> next-state observation in an 8-bit rule table.
module ca_rule_inferrer #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1,
  parameter int CNTW  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_gen_in,
  input  logic             i_gen_valid,
  output logic             o_gen_ready,
  output logic [7:0]       o_rule_out,
  output logic [7:0]       o_rule_known,
  output logic             o_complete,
  output logic             o_conflict,
  output logic             o_pair_done,
  output logic [CNTW-1:0]  o_pairs
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int EXTW = WIDTH + 2;
  localparam int EXW  = $clog2(EXTW);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_prev, r_cur;
  logic             r_have_prev;
  logic [IDXW-1:0]  r_idx;
  logic [7:0]       r_rule, r_known;
  logic             r_conflict, r_pair_done;
  logic [CNTW-1:0]  r_pairs;

  logic             w_accept, w_last, w_next_bit, w_clash;
  logic             w_edge_hi, w_edge_lo;
  logic [EXTW-1:0]  w_prev_ext;
  logic [EXW-1:0]   w_base;
  logic [2:0]       w_p;

  // Pad the previous generation with one guard cell on each side so that the
  // neighbourhood of cell idx is simply bits [idx+2:idx] of the padded word.
  assign w_edge_hi  = WRAP ? r_prev[0]       : 1'b0;
  assign w_edge_lo  = WRAP ? r_prev[WIDTH-1] : 1'b0;
  assign w_prev_ext = {w_edge_hi, r_prev, w_edge_lo};
  assign w_base     = EXW'(r_idx);
  assign w_p        = w_prev_ext[w_base +: 3];
  assign w_next_bit = r_cur[r_idx];
  assign w_clash    = r_known[w_p] & (r_rule[w_p] != w_next_bit);
  assign w_last     = (r_idx == LAST_IDX);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = i_gen_valid;
        if (i_gen_valid && r_have_prev) w_state_next = S_SCAN;
      end
      S_SCAN: begin
        if (w_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (i_clear) begin
      w_state_next = S_IDLE;
      w_accept     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_cur       <= '0;
      r_have_prev <= 1'b0;
      r_idx       <= '0;
      r_rule      <= '0;
      r_known     <= '0;
      r_conflict  <= 1'b0;
      r_pair_done <= 1'b0;
      r_pairs     <= '0;
    end else if (i_clear) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_cur       <= '0;
      r_have_prev <= 1'b0;
      r_idx       <= '0;
      r_rule      <= '0;
      r_known     <= '0;
      r_conflict  <= 1'b0;
      r_pair_done <= 1'b0;
      r_pairs     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pair_done <= 1'b0;
      if (w_accept) begin
        if (r_have_prev) begin
          r_cur <= i_gen_in;
          r_idx <= '0;
        end else begin
          r_prev      <= i_gen_in;
          r_have_prev <= 1'b1;
        end
      end
      if (r_state == S_SCAN) begin
        // A contradiction is flagged but never overwrites what was learned first.
        if (w_clash) begin
          r_conflict <= 1'b1;
        end else begin
          r_rule[w_p]  <= w_next_bit;
          r_known[w_p] <= 1'b1;
        end
        if (w_last) begin
          r_prev      <= r_cur;
          r_pair_done <= 1'b1;
          if (r_pairs != '1) r_pairs <= r_pairs + 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign o_gen_ready  = (r_state == S_IDLE);
  assign o_rule_out   = r_rule;
  assign o_rule_known = r_known;
  assign o_complete   = &r_known;
  assign o_conflict   = r_conflict;
  assign o_pair_done  = r_pair_done;
  assign o_pairs      = r_pairs;

endmodule

// File: tb/tb_ca_rule_inferrer.sv
// Directed bench for ca_rule_inferrer: a reference model pushes expected rule state per pair,
// popped and compared when the DUT pulses pair_done.
module tb_ca_rule_inferrer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_clear = 1'b0, a_valid = 1'b0;
  logic [7:0] a_gen = '0;
  logic       a_ready, a_complete, a_conflict, a_pair_done;
  logic [7:0] a_rule, a_known, a_pairs;

  logic       b_clear = 1'b0, b_valid = 1'b0;
  logic [7:0] b_gen = '0;
  logic       b_ready, b_complete, b_conflict, b_pair_done;
  logic [7:0] b_rule, b_known, b_pairs;

  ca_rule_inferrer #(.WIDTH(8), .WRAP(1'b1), .CNTW(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(a_clear), .i_gen_in(a_gen), .i_gen_valid(a_valid),
    .o_gen_ready(a_ready), .o_rule_out(a_rule), .o_rule_known(a_known),
    .o_complete(a_complete), .o_conflict(a_conflict), .o_pair_done(a_pair_done),
    .o_pairs(a_pairs)
  );

  ca_rule_inferrer #(.WIDTH(8), .WRAP(1'b0), .CNTW(8)) dut_nowrap (
    .i_clk(clk), .i_rst(rst), .i_clear(b_clear), .i_gen_in(b_gen), .i_gen_valid(b_valid),
    .o_gen_ready(b_ready), .o_rule_out(b_rule), .o_rule_known(b_known),
    .o_complete(b_complete), .o_conflict(b_conflict), .o_pair_done(b_pair_done),
    .o_pairs(b_pairs)
  );

  typedef struct packed {
    logic [7:0] rule;
    logic [7:0] known;
    logic       conflict;
    logic [7:0] pairs;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   sel = 1'b0;

  logic [7:0] m_prev, m_rule, m_known, m_pairs;
  bit         m_have, m_conflict;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] nbhd(input logic [7:0] g, input int i, input bit wrap);
    logic l, r;
    l = (i == 7) ? (wrap ? g[0] : 1'b0) : g[i+1];
    r = (i == 0) ? (wrap ? g[7] : 1'b0) : g[i-1];
    return {l, g[i], r};
  endfunction

  function automatic logic [7:0] next_gen(input logic [7:0] rule, input logic [7:0] g, input bit wrap);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) n[i] = rule[nbhd(g, i, wrap)];
    return n;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_rule = '0; m_known = '0; m_pairs = '0;
    m_have = 1'b0; m_conflict = 1'b0;
    sb.delete();
  endtask

  task automatic model_learn(input logic [7:0] pv, input logic [7:0] cv, input bit wrap);
    logic [2:0] p;
    for (int i = 0; i < 8; i++) begin
      p = nbhd(pv, i, wrap);
      if (m_known[p] && (m_rule[p] != cv[i])) m_conflict = 1'b1;
      else begin
        m_rule[p]  = cv[i];
        m_known[p] = 1'b1;
      end
    end
    if (m_pairs != 8'hFF) m_pairs = m_pairs + 8'd1;
  endtask

  function automatic logic cur_ready();
    return sel ? b_ready : a_ready;
  endfunction

  function automatic logic cur_pd();
    return sel ? b_pair_done : a_pair_done;
  endfunction

  task automatic drive(input logic [7:0] w, input logic v);
    if (sel) begin b_gen = w; b_valid = v; end
    else begin a_gen = w; a_valid = v; end
  endtask

  task automatic drop();
    if (sel) b_valid = 1'b0; else a_valid = 1'b0;
  endtask

  task automatic check_outputs(input string pfx, input logic [7:0] rule, input logic [7:0] known,
                               input logic conflict, input logic [7:0] pairs);
    check({pfx, ".rule"},     sel ? b_rule     : a_rule,     rule);
    check({pfx, ".known"},    sel ? b_known    : a_known,    known);
    check({pfx, ".conflict"}, sel ? b_conflict : a_conflict, conflict);
    check({pfx, ".pairs"},    sel ? b_pairs    : a_pairs,    pairs);
    check({pfx, ".complete"}, sel ? b_complete : a_complete, &known);
  endtask

  task automatic check_reset(input string pfx);
    check_outputs(pfx, 8'h00, 8'h00, 1'b0, 8'h00);
    check({pfx, ".pair_done"}, cur_pd(), 1'b0);
    check({pfx, ".ready"}, cur_ready(), 1'b1);
  endtask

  task automatic send(input logic [7:0] w);
    bit ok = 1'b0;
    drive(w, 1'b1);
    for (int k = 0; k < 40; k++) begin
      if (cur_ready()) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", ok, 1'b1);
    check("pair_done_single", cur_pd(), 1'b0);
    if (!m_have) begin
      m_prev = w;
      m_have = 1'b1;
    end else begin
      model_learn(m_prev, w, !sel);
      m_prev = w;
      sb.push_back('{rule: m_rule, known: m_known, conflict: m_conflict, pairs: m_pairs});
    end
    $display("send sel=%0d word=%02h", sel, w);
  endtask

  task automatic wait_done();
    int   low = 0;
    bit   seen = 1'b0;
    exp_t e;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cur_pd()) begin seen = 1'b1; break; end
      if (!cur_ready()) low++;
    end
    check("pair_done_seen", seen, 1'b1);
    check("ready_low_cycles", low, 8);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_outputs("pair", e.rule, e.known, e.conflict, e.pairs);
      $display("pair done sel=%0d rule=%02h known=%02h conflict=%0d pairs=%0d",
               sel, e.rule, e.known, e.conflict, e.pairs);
    end else begin
      n_cmp++;
      n_mis++;
      $error("FAIL scoreboard: observed pair_done, expected no pending pair");
    end
  endtask

  task automatic pulse_clear();
    drop();
    if (sel) b_clear = 1'b1; else a_clear = 1'b1;
    @(posedge clk); #1;
    if (sel) b_clear = 1'b0; else a_clear = 1'b0;
    model_reset();
    check_reset("clear");
  endtask

  logic [7:0] g;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("por");

    // Rule 110 single pair
    send(8'h10);
    send(8'h30);
    wait_done();
    drop();
    check_outputs("t1", 8'h06, 8'h17, 1'b0, 8'h01);
    pulse_clear();

    // Rule 110 stream with valid held high the whole time
    g = 8'h01;
    for (int n = 0; n < 20; n++) begin
      send(g);
      if (n > 0) wait_done();
      g = next_gen(8'd110, g, 1'b1);
    end
    drop();
    check_outputs("t2", 8'h6E, 8'hFF, 1'b0, 8'd19);
    pulse_clear();

    // Contradiction: cell 0 learns p=0 -> 1, later cells contradict it
    send(8'h00);
    send(8'h01);
    wait_done();
    drop();
    check_outputs("t3", 8'h01, 8'h01, 1'b1, 8'h01);
    pulse_clear();

    // Zero-padded edges on the non-wrapping instance
    sel = 1'b1;
    model_reset();
    send(8'h01);
    send(8'h02);
    wait_done();
    drop();
    check_outputs("t5", 8'h02, 8'h07, 1'b0, 8'h01);
    sel = 1'b0;

    // CLEAR while the scan sits at idx 3, then restart from an empty history
    send(8'h55);
    send(8'hAA);
    repeat (3) @(posedge clk);
    #1;
    pulse_clear();
    send(8'h0F);
    check("restart.no_scan", a_ready, 1'b1);
    send(8'h1E);
    wait_done();
    drop();

    // Asynchronous reset between clock edges in the middle of a scan
    send(8'h33);
    send(8'h66);
    @(posedge clk);
    drop();
    #3;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 8'h00, 8'h00, 1'b0, 8'h00);
    check("async_rst.pair_done", a_pair_done, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst.ready", a_ready, 1'b1);
    send(8'h12);
    send(8'h24);
    wait_done();
    drop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
